// File: rtl/dsky_serial_rx_pkg.sv
// Shared definitions for the DSKY serial receiver: sync byte, register indices,
// FSM state encodings and the packet checksum.
package dsky_serial_rx_pkg;

  localparam logic [7:0]  DSKY_SYNC_BYTE = 8'hA5;
  localparam int unsigned DSKY_NUM_REGS  = 5;

  typedef enum logic [2:0] {
    VERB    = 3'd0,
    NOUN    = 3'd1,
    MTIME   = 3'd2,
    APOGEE  = 3'd3,
    PERIGEE = 3'd4
  } dsky_reg_idx_t;

  typedef logic [1:0] uart_state_t;
  localparam uart_state_t U_IDLE  = 2'd0;
  localparam uart_state_t U_START = 2'd1;
  localparam uart_state_t U_DATA  = 2'd2;
  localparam uart_state_t U_STOP  = 2'd3;

  typedef logic [2:0] parser_state_t;
  localparam parser_state_t P_SYNC = 3'd0;
  localparam parser_state_t P_IDX  = 3'd1;
  localparam parser_state_t P_HI   = 3'd2;
  localparam parser_state_t P_LO   = 3'd3;
  localparam parser_state_t P_CK   = 3'd4;

  // 8-bit XOR of the index, hi and lo bytes of a packet
  function automatic logic [7:0] dsky_cksum(input logic [2:0] idx,
                                            input logic [6:0] hi,
                                            input logic [7:0] lo);
    return {5'd0, idx} ^ {1'b0, hi} ^ lo;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Emits one-cycle byte_valid or frame_err pulses at the stop-bit sample.
module uart_rx_byte
  import dsky_serial_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic              r_sync1;
  logic              r_rx_s;
  uart_state_t       r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_valid;
  logic              r_ferr;

  uart_state_t       w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_valid_nxt;
  logic              w_ferr_nxt;

  assign rx_data    = r_shift;
  assign byte_valid = r_valid;
  assign frame_err  = r_ferr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= U_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      U_IDLE: begin
        if (!r_rx_s) begin
          w_cnt_nxt   = CW'(CLKS_PER_BIT / 2);
          w_state_nxt = U_START;
        end
      end
      U_START: begin
        if (r_cnt == CW'(0)) begin
          // A start bit that has gone high again by mid-bit is line noise
          if (r_rx_s) begin
            w_state_nxt = U_IDLE;
          end else begin
            w_cnt_nxt   = CW'(CLKS_PER_BIT - 1);
            w_bit_nxt   = 3'd0;
            w_state_nxt = U_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      U_DATA: begin
        if (r_cnt == CW'(0)) begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_cnt_nxt   = CW'(CLKS_PER_BIT - 1);
          if (r_bit == 3'd7) begin
            w_state_nxt = U_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      U_STOP: begin
        if (r_cnt == CW'(0)) begin
          w_valid_nxt = r_rx_s;
          w_ferr_nxt  = !r_rx_s;
          w_state_nxt = U_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = U_IDLE;
    endcase
  end

endmodule

// File: rtl/dsky_serial_rx.sv
// DSKY serial front end: parses A5/idx/hi/lo/ck packets from the UART byte
// stream and holds the five 15-bit CPU input registers.
module dsky_serial_rx
  import dsky_serial_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 17360
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic [14:0] dsky_verb,
  output logic [14:0] dsky_noun,
  output logic [14:0] mission_time,
  output logic [14:0] apogee,
  output logic [14:0] perigee,
  output logic        pkt_valid,
  output logic [2:0]  pkt_idx,
  output logic        frame_err,
  output logic        pkt_err
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [7:0]     w_data;
  logic           w_byte_valid;
  logic           w_frame_err;

  parser_state_t  r_pstate;
  dsky_reg_idx_t  r_idx;
  logic [6:0]     r_hi;
  logic [7:0]     r_lo;
  logic [TW-1:0]  r_timer;
  logic [14:0]    r_regs [DSKY_NUM_REGS];
  logic           r_pkt_valid;
  logic [2:0]     r_pkt_idx;
  logic           r_pkt_err;

  parser_state_t  w_pstate_nxt;
  dsky_reg_idx_t  w_idx_nxt;
  logic [6:0]     w_hi_nxt;
  logic [7:0]     w_lo_nxt;
  logic [TW-1:0]  w_timer_nxt;
  logic [14:0]    w_regs_nxt [DSKY_NUM_REGS];
  logic           w_pkt_valid_nxt;
  logic [2:0]     w_pkt_idx_nxt;
  logic           w_pkt_err_nxt;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_data    (w_data),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err)
  );

  assign dsky_verb    = r_regs[0];
  assign dsky_noun    = r_regs[1];
  assign mission_time = r_regs[2];
  assign apogee       = r_regs[3];
  assign perigee      = r_regs[4];
  assign pkt_valid    = r_pkt_valid;
  assign pkt_idx      = r_pkt_idx;
  assign pkt_err      = r_pkt_err;
  assign frame_err    = w_frame_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pstate    <= P_SYNC;
      r_idx       <= VERB;
      r_hi        <= '0;
      r_lo        <= '0;
      r_timer     <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_idx   <= '0;
      r_pkt_err   <= 1'b0;
      for (int i = 0; i < int'(DSKY_NUM_REGS); i++) r_regs[i] <= '0;
    end else begin
      r_pstate    <= w_pstate_nxt;
      r_idx       <= w_idx_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_timer     <= w_timer_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_pkt_idx   <= w_pkt_idx_nxt;
      r_pkt_err   <= w_pkt_err_nxt;
      r_regs      <= w_regs_nxt;
    end
  end

  // Frame error beats everything; otherwise a byte advances the parser,
  // and with no byte the inter-byte timer runs while a packet is open.
  always_comb begin
    w_pstate_nxt    = r_pstate;
    w_idx_nxt       = r_idx;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_timer_nxt     = r_timer;
    w_regs_nxt      = r_regs;
    w_pkt_valid_nxt = 1'b0;
    w_pkt_idx_nxt   = r_pkt_idx;
    w_pkt_err_nxt   = 1'b0;
    if (w_frame_err) begin
      w_pstate_nxt = P_SYNC;
      w_timer_nxt  = '0;
    end else if (w_byte_valid) begin
      w_timer_nxt = '0;
      case (r_pstate)
        P_SYNC: begin
          if (w_data == DSKY_SYNC_BYTE) w_pstate_nxt = P_IDX;
        end
        P_IDX: begin
          if (w_data < 8'(DSKY_NUM_REGS)) begin
            w_idx_nxt    = dsky_reg_idx_t'(w_data[2:0]);
            w_pstate_nxt = P_HI;
          end else begin
            w_pkt_err_nxt = 1'b1;
            w_pstate_nxt  = P_SYNC;
          end
        end
        P_HI: begin
          if (w_data[7]) begin
            w_pkt_err_nxt = 1'b1;
            w_pstate_nxt  = P_SYNC;
          end else begin
            w_hi_nxt     = w_data[6:0];
            w_pstate_nxt = P_LO;
          end
        end
        P_LO: begin
          w_lo_nxt     = w_data;
          w_pstate_nxt = P_CK;
        end
        P_CK: begin
          if (w_data == dsky_cksum(r_idx, r_hi, r_lo)) begin
            w_regs_nxt[r_idx] = {r_hi, r_lo};
            w_pkt_valid_nxt   = 1'b1;
            w_pkt_idx_nxt     = r_idx;
          end else begin
            w_pkt_err_nxt = 1'b1;
          end
          w_pstate_nxt = P_SYNC;
        end
        default: w_pstate_nxt = P_SYNC;
      endcase
    end else if (r_pstate != P_SYNC) begin
      if (r_timer == TW'(TIMEOUT_CLKS - 1)) begin
        w_pkt_err_nxt = 1'b1;
        w_pstate_nxt  = P_SYNC;
        w_timer_nxt   = '0;
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dsky_serial_rx.sv
// Scoreboard bench for dsky_serial_rx: a byte-queue packet model predicts each
// pulse and the register file; a monitor pops and compares on every DUT pulse.
module tb_dsky_serial_rx;

  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 400;

  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_PERR  = 2'd2;
  localparam logic [1:0] EV_FERR  = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [2:0]        idx;
    logic [4:0][14:0]  regs;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [14:0] dsky_verb, dsky_noun, mission_time, apogee, perigee;
  logic        pkt_valid, frame_err, pkt_err;
  logic [2:0]  pkt_idx;

  ev_t              exp_q[$];
  logic [4:0][14:0] m_regs;
  logic [2:0]       m_idx;
  logic [7:0]       m_pkt[$];
  int               n_checks = 0;
  int               n_errors = 0;

  dsky_serial_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clock        (clk),
    .reset_n      (rst_n),
    .rx           (rx),
    .dsky_verb    (dsky_verb),
    .dsky_noun    (dsky_noun),
    .mission_time (mission_time),
    .apogee       (apogee),
    .perigee      (perigee),
    .pkt_valid    (pkt_valid),
    .pkt_idx      (pkt_idx),
    .frame_err    (frame_err),
    .pkt_err      (pkt_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0][14:0] dut_regs();
    return {perigee, apogee, mission_time, dsky_noun, dsky_verb};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input logic [1:0] k);
    ev_t e;
    e.kind = k;
    e.idx  = m_idx;
    e.regs = m_regs;
    exp_q.push_back(e);
  endfunction

  // Packet model: collect bytes after a sync byte and judge each on arrival
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] ib, hb, lb;
    case (m_pkt.size())
      0: if (b == 8'hA5) m_pkt.push_back(b);
      1: begin
        if (b > 8'd4) begin push_ev(EV_PERR); m_pkt.delete(); end
        else m_pkt.push_back(b);
      end
      2: begin
        if (b[7]) begin push_ev(EV_PERR); m_pkt.delete(); end
        else m_pkt.push_back(b);
      end
      3: m_pkt.push_back(b);
      default: begin
        ib = m_pkt[1];
        hb = m_pkt[2];
        lb = m_pkt[3];
        if (b == (ib ^ hb ^ lb)) begin
          m_idx         = ib[2:0];
          m_regs[m_idx] = {hb[6:0], lb};
          push_ev(EV_VALID);
        end else begin
          push_ev(EV_PERR);
        end
        m_pkt.delete();
      end
    endcase
  endfunction

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    gap(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) model_byte(b);
    else begin push_ev(EV_FERR); m_pkt.delete(); end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] idx, input logic [7:0] hi,
                          input logic [7:0] lo, input logic [7:0] ck);
    send_byte(8'hA5, 1'b1); gap(2);
    send_byte(idx, 1'b1);   gap(2);
    send_byte(hi, 1'b1);    gap(2);
    send_byte(lo, 1'b1);    gap(2);
    send_byte(ck, 1'b1);    gap(2);
  endtask

  task automatic idle_timeout();
    if (m_pkt.size() != 0) begin push_ev(EV_PERR); m_pkt.delete(); end
    gap(500);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    m_regs = '0;
    m_idx  = '0;
    m_pkt.delete();
    exp_q.delete();
    gap(3);
    chk("reset_regs", 80'(dut_regs()), 80'(0));
    chk("reset_idx", 80'(pkt_idx), 80'(0));
    chk("reset_flags", 80'({pkt_valid, pkt_err, frame_err}), 80'(0));
    rst_n = 1'b1;
    gap(2);
  endtask

  // Monitor: every output pulse must match the next predicted event
  always @(negedge clk) begin
    ev_t        e;
    logic [1:0] k;
    if (rst_n === 1'b1 && (pkt_valid || pkt_err || frame_err)) begin
      k = pkt_valid ? EV_VALID : (pkt_err ? EV_PERR : EV_FERR);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 80'(k), 80'(e.kind));
        chk("pkt_idx", 80'(pkt_idx), 80'(e.idx));
        chk("regs", 80'(dut_regs()), 80'(e.regs));
        chk("pulse_excl", 80'(pkt_valid & pkt_err), 80'(0));
      end
    end
  end

  initial begin
    logic [14:0] val;
    logic [7:0]  idxb, hib, lob, ckb;
    int          mode;

    do_reset();

    send_pkt(8'h00, 8'h01, 8'h23, 8'h22);
    gap(20);
    chk("t1_verb", 80'(dsky_verb), 80'(15'h0123));
    chk("t1_others", 80'(dut_regs()), 80'(75'h0123));

    send_pkt(8'h04, 8'h7F, 8'hFF, 8'h84);
    gap(20);
    chk("t2_perigee", 80'(perigee), 80'(15'h7FFF));
    chk("t2_idx", 80'(pkt_idx), 80'(4));
    send_pkt(8'h01, 8'h00, 8'h05, 8'h00);
    gap(20);
    chk("t2_noun_kept", 80'(dsky_noun), 80'(0));

    send_pkt(8'h02, 8'h80, 8'h00, 8'h82);
    gap(20);
    chk("t3_mtime_kept", 80'(mission_time), 80'(0));
    send_pkt(8'h07, 8'h00, 8'h00, 8'h00);
    gap(20);

    send_byte(8'hA5, 1'b1); gap(2);
    send_byte(8'h03, 1'b1); gap(2);
    send_byte(8'h55, 1'b0); gap(20);
    send_pkt(8'h03, 8'h12, 8'h34, 8'h25);
    gap(20);
    chk("t4_apogee", 80'(apogee), 80'(15'h1234));

    send_byte(8'hA5, 1'b1); gap(2);
    send_byte(8'h01, 1'b1);
    idle_timeout();
    send_byte(8'h00, 1'b1); gap(2);
    send_byte(8'h05, 1'b1); gap(2);
    send_byte(8'h05, 1'b1); gap(20);
    chk("t5_noun_kept", 80'(dsky_noun), 80'(0));

    rx = 1'b0; gap(3); rx = 1'b1; gap(40);

    send_byte(8'hA5, 1'b1); gap(2);
    send_byte(8'h02, 1'b1); gap(2);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); gap(CPB / 2);
    do_reset();
    send_pkt(8'h02, 8'h2A, 8'h55, 8'h02 ^ 8'h2A ^ 8'h55);
    gap(20);
    chk("t6_mtime", 80'(mission_time), 80'(15'h2A55));

    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 9));
      val  = 15'($urandom);
      idxb = 8'($urandom_range(0, 4));
      hib  = {1'b0, val[14:8]};
      lob  = val[7:0];
      ckb  = idxb ^ hib ^ lob;
      if (mode == 1) idxb = 8'($urandom_range(5, 255));
      if (mode == 2) ckb  = ckb ^ 8'($urandom_range(1, 255));
      if (mode == 3) hib  = hib | 8'h80;
      if (mode == 0) begin
        send_byte(8'($urandom), 1'b1);
        gap(int'($urandom_range(0, 12)));
      end else begin
        send_byte(8'hA5, 1'b1); gap(int'($urandom_range(0, 12)));
        send_byte(idxb, 1'b1);  gap(int'($urandom_range(0, 12)));
        send_byte(hib, 1'b1);   gap(int'($urandom_range(0, 12)));
        send_byte(lob, 1'b1);   gap(int'($urandom_range(0, 12)));
        send_byte(ckb, 1'b1);   gap(int'($urandom_range(0, 12)));
      end
    end

    idle_timeout();
    gap(50);
    chk("queue_drained", 80'(exp_q.size()), 80'(0));
    chk("final_regs", 80'(dut_regs()), 80'(m_regs));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
